// File: rtl/mkio_pkg.sv
// mkio_pkg: shared types, field positions and helpers for the MKIO bus-controller sequencer
package mkio_pkg;
  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_SEND_CMD    = 4'd1,
    S_FETCH       = 4'd2,
    S_SEND_DATA   = 4'd3,
    S_WAIT_STATUS = 4'd4,
    S_RECV_DATA   = 4'd5,
    S_CHECK       = 4'd6,
    S_RETRY_GAP   = 4'd7,
    S_DONE        = 4'd8
  } seq_state_t;
  localparam int CW_RT_LSB   = 11;
  localparam int CW_TR_BIT   = 10;
  localparam int CW_SA_LSB   = 5;
  localparam int CW_WC_LSB   = 0;
  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_FORMAT  = 1;
  localparam int ERR_ADDR    = 2;
  localparam int ERR_MSG     = 3;
  localparam int SW_ADDR_LSB = 11;
  localparam int SW_ME_BIT   = 10;
  function automatic logic [15:0] mkio_cmd_word(input logic [4:0] rt, input logic tr,
                                                input logic [4:0] sa, input logic [4:0] wc);
    logic [15:0] w;
    w = '0;
    w[CW_RT_LSB +: 5] = rt;
    w[CW_TR_BIT]      = tr;
    w[CW_SA_LSB +: 5] = sa;
    w[CW_WC_LSB +: 5] = wc;
    return w;
  endfunction
endpackage

// File: rtl/mkio_resp_timer.sv
// mkio_resp_timer: loadable down-counter, expired while enabled and at zero
// Ports: clk, reset (async, active-high), load/value reload the count,
//        en counts down and qualifies expired.
module mkio_resp_timer #(
  parameter int RESP_TIMEOUT = 700,
  localparam int W = $clog2(RESP_TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load) cnt_q <= value;
    else if (en && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign expired = en && cnt_q == '0;
endmodule

// File: rtl/mkio_bc_sequencer.sv
// mkio_bc_sequencer: MKIO bus-controller transfer sequencer with status check, timeout and retry
// Ports: cmd_* request (one at a time, cmd_ready in IDLE); tx_* word handshake to encoder;
//        rx_* decoded words; mem_* transmit buffer (1-cycle read); rxbuf_* receive buffer writes;
//        busy/done/status_word/err_flags transfer result.
module mkio_bc_sequencer import mkio_pkg::*; #(
  parameter int RESP_TIMEOUT = 700,
  parameter int RETRIES      = 1,
  parameter int RETRY_GAP    = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_rt,
  input  logic        cmd_tr,
  input  logic [4:0]  cmd_sa,
  input  logic [4:0]  cmd_wc,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  output logic        tx_ready,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic [4:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic        rxbuf_we,
  output logic [4:0]  rxbuf_addr,
  output logic [15:0] rxbuf_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] status_word,
  output logic [3:0]  err_flags
);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam int AW = $clog2(RETRIES + 2);
  localparam int GW = $clog2(RETRY_GAP + 2);
  localparam logic [AW-1:0] RETRY_MAX = AW'(RETRIES);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(RETRY_GAP > 0 ? RETRY_GAP - 1 : 0);
  seq_state_t    st_q, st_d;
  logic [4:0]    rt_q, rt_d, sa_q, sa_d, wc_q, wc_d, idx_q, idx_d, waddr_q, waddr_d;
  logic          tr_q, tr_d, ph_q, ph_d, we_q, we_d;
  logic [AW-1:0] att_q, att_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   status_q, status_d, wdata_q, wdata_d;
  logic [3:0]    err_q, err_d;
  logic          sending, tx_fin, last, tmr_en, expired;
  assign sending = st_q == S_SEND_CMD || st_q == S_SEND_DATA;
  // ph_q: 0 = presenting the word, 1 = encoder accepted it, waiting for it to finish
  assign tx_fin  = ph_q && !tx_busy;
  // wc = 0 wraps to 31, so the last index is wc-1 for every count including 32
  assign last    = idx_q == wc_q - 5'd1;
  assign tmr_en  = st_q == S_WAIT_STATUS || st_q == S_RECV_DATA;
  mkio_resp_timer #(.RESP_TIMEOUT(RESP_TIMEOUT)) u_timer (
    .clk(clk), .reset(reset), .load(!tmr_en || rx_done), .value(TW'(RESP_TIMEOUT)),
    .en(tmr_en), .expired(expired)
  );
  always_comb begin
    st_d = st_q;
    rt_d = rt_q;
    tr_d = tr_q;
    sa_d = sa_q;
    wc_d = wc_q;
    idx_d = idx_q;
    att_d = att_q;
    gap_d = gap_q;
    status_d = status_q;
    err_d = err_q;
    we_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ph_d = sending && tx_busy;
    case (st_q)
      S_IDLE: if (cmd_valid) begin
        st_d = S_SEND_CMD;
        rt_d = cmd_rt;
        tr_d = cmd_tr;
        sa_d = cmd_sa;
        wc_d = cmd_wc;
        idx_d = '0;
        att_d = '0;
        status_d = '0;
        err_d = '0;
      end
      S_SEND_CMD: if (tx_fin) st_d = tr_q ? S_WAIT_STATUS : S_FETCH;
      S_FETCH: st_d = S_SEND_DATA;
      S_SEND_DATA: if (tx_fin) begin
        st_d = last ? S_WAIT_STATUS : S_FETCH;
        idx_d = last ? idx_q : idx_q + 5'd1;
      end
      S_WAIT_STATUS: if (rx_done) begin
        if (!rx_cd) begin
          err_d[ERR_FORMAT] = 1'b1;
          st_d = S_CHECK;
        end else begin
          status_d = rx_data;
          err_d[ERR_FORMAT] = err_q[ERR_FORMAT] | p_error;
          err_d[ERR_ADDR] = rx_data[SW_ADDR_LSB +: 5] != rt_q;
          err_d[ERR_MSG] = rx_data[SW_ME_BIT];
          st_d = tr_q ? S_RECV_DATA : S_CHECK;
        end
      end else if (expired) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        st_d = S_CHECK;
      end
      S_RECV_DATA: if (rx_done) begin
        if (rx_cd) begin
          err_d[ERR_FORMAT] = 1'b1;
          st_d = S_CHECK;
        end else begin
          we_d = 1'b1;
          waddr_d = idx_q;
          wdata_d = rx_data;
          err_d[ERR_FORMAT] = err_q[ERR_FORMAT] | p_error;
          idx_d = last ? idx_q : idx_q + 5'd1;
          st_d = last ? S_CHECK : S_RECV_DATA;
        end
      end else if (expired) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        st_d = S_CHECK;
      end
      S_CHECK: begin
        st_d = err_q == '0 || att_q >= RETRY_MAX ? S_DONE : S_RETRY_GAP;
        gap_d = GAP_LOAD;
        att_d = err_q != '0 && att_q < RETRY_MAX ? att_q + AW'(1) : att_q;
      end
      S_RETRY_GAP: if (gap_q == '0) begin
        st_d = S_SEND_CMD;
        idx_d = '0;
        err_d = '0;
      end else gap_d = gap_q - GW'(1);
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= S_IDLE;
      rt_q <= '0;
      tr_q <= 1'b0;
      sa_q <= '0;
      wc_q <= '0;
      idx_q <= '0;
      ph_q <= 1'b0;
      att_q <= '0;
      gap_q <= '0;
      status_q <= '0;
      err_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      st_q <= st_d;
      rt_q <= rt_d;
      tr_q <= tr_d;
      sa_q <= sa_d;
      wc_q <= wc_d;
      idx_q <= idx_d;
      ph_q <= ph_d;
      att_q <= att_d;
      gap_q <= gap_d;
      status_q <= status_d;
      err_q <= err_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  assign cmd_ready   = st_q == S_IDLE;
  assign busy        = st_q != S_IDLE;
  assign done        = st_q == S_DONE;
  assign tx_ready    = sending && !ph_q;
  assign tx_cd       = st_q == S_SEND_CMD;
  assign tx_data     = st_q == S_SEND_CMD ? mkio_cmd_word(rt_q, tr_q, sa_q, wc_q) :
                       st_q == S_SEND_DATA ? mem_data : '0;
  assign mem_addr    = idx_q;
  assign rxbuf_we    = we_q;
  assign rxbuf_addr  = waddr_q;
  assign rxbuf_data  = wdata_q;
  assign status_word = status_q;
  assign err_flags   = err_q;
endmodule

// File: tb/tb_mkio_bc_sequencer.sv
// tb_mkio_bc_sequencer: directed scoreboard bench for the MKIO bus-controller sequencer
module tb_mkio_bc_sequencer;
  localparam int RT = 700;
  localparam int RG = 50;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_tr = 1'b0;
  logic [4:0]  cmd_rt = '0, cmd_sa = '0, cmd_wc = '0;
  logic [15:0] tx_data;
  logic        tx_cd, tx_ready, tx_busy = 1'b0;
  logic        rx_done = 1'b0, rx_cd = 1'b0, p_error = 1'b0;
  logic [15:0] rx_data = '0;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic        rxbuf_we;
  logic [4:0]  rxbuf_addr;
  logic [15:0] rxbuf_data;
  logic        busy, done;
  logic [15:0] status_word;
  logic [3:0]  err_flags;
  logic [15:0] mem [32];
  logic [16:0] exp_tx [$];
  int total = 0, bad = 0, cyc = 0, last_tx_cyc = 0, done_cyc = 0, acc_cyc = 0, t1 = 0;
  bit seen_done;
  mkio_bc_sequencer #(.RESP_TIMEOUT(RT), .RETRIES(1), .RETRY_GAP(RG)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rt(cmd_rt),
    .cmd_tr(cmd_tr), .cmd_sa(cmd_sa), .cmd_wc(cmd_wc), .tx_data(tx_data), .tx_cd(tx_cd),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .rx_done(rx_done), .rx_data(rx_data), .rx_cd(rx_cd),
    .p_error(p_error), .mem_addr(mem_addr), .mem_data(mem_data), .rxbuf_we(rxbuf_we),
    .rxbuf_addr(rxbuf_addr), .rxbuf_data(rxbuf_data), .busy(busy), .done(done),
    .status_word(status_word), .err_flags(err_flags)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mem_data <= mem[mem_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input string tag, input logic [4:0] rt, input logic tr,
                       input logic [4:0] sa, input logic [4:0] wc);
    cmd_rt = rt; cmd_tr = tr; cmd_sa = sa; cmd_wc = wc; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    acc_cyc = cyc;
    chk({tag, " busy"}, busy, 1);
    chk({tag, " cmd_ready"}, cmd_ready, 0);
    chk({tag, " err clr"}, err_flags, 0);
    chk({tag, " status clr"}, status_word, 0);
  endtask
  task automatic serve_tx(input string tag, input int limit);
    int n;
    logic [16:0] e;
    n = 0;
    while (!tx_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " tx_ready"}, tx_ready, 1);
    if (tx_ready) begin
      last_tx_cyc = cyc;
      e = 17'h1ffff;
      if (exp_tx.size() > 0) e = exp_tx.pop_front();
      chk({tag, " tx_data"}, tx_data, e[15:0]);
      chk({tag, " tx_cd"}, tx_cd, e[16]);
      tx_busy = 1'b1;
      @(negedge clk);
      chk({tag, " tx_ready drop"}, tx_ready, 0);
      repeat (2) @(negedge clk);
      tx_busy = 1'b0;
    end
  endtask
  task automatic rx_word(input string tag, input logic [15:0] d, input logic cd, input logic pe,
                         input logic exp_we, input logic [4:0] exp_addr);
    @(negedge clk);
    rx_done = 1'b1; rx_data = d; rx_cd = cd; p_error = pe;
    @(negedge clk);
    rx_done = 1'b0; p_error = 1'b0;
    chk({tag, " we"}, rxbuf_we, exp_we);
    if (exp_we) begin
      chk({tag, " waddr"}, rxbuf_addr, exp_addr);
      chk({tag, " wdata"}, rxbuf_data, d);
    end
  endtask
  task automatic wait_done(input string tag, input logic [3:0] e_err, input logic [15:0] e_st,
                           input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    chk({tag, " done"}, done, 1);
    chk({tag, " err_flags"}, err_flags, e_err);
    chk({tag, " status_word"}, status_word, e_st);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle"}, cmd_ready, 1);
    chk({tag, " err hold"}, err_flags, e_err);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    #1;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst busy", busy, 0);
    chk("rst tx_ready", tx_ready, 0);
    chk("rst done", done, 0);
    chk("rst err", err_flags, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst status", status_word, 0);
    chk("rst rxbuf_we", rxbuf_we, 0);
    // BC->RT, three words; a request held during the transfer must be ignored
    mem[0] = 16'hA001; mem[1] = 16'hA002; mem[2] = 16'hA003;
    issue("t1", 5'd5, 1'b0, 5'd2, 5'd3);
    exp_tx.push_back({1'b1, 16'h2843});
    exp_tx.push_back({1'b0, 16'hA001});
    exp_tx.push_back({1'b0, 16'hA002});
    exp_tx.push_back({1'b0, 16'hA003});
    cmd_rt = 5'd9; cmd_valid = 1'b1;
    serve_tx("t1 cmd", 20);
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) serve_tx("t1 data", 20);
    rx_word("t1 status", 16'h2800, 1'b1, 1'b0, 1'b0, 5'd0);
    wait_done("t1", 4'b0000, 16'h2800, 20);
    // RT->BC, wc = 0 means 32 words
    issue("t2", 5'd1, 1'b1, 5'd0, 5'd0);
    exp_tx.push_back({1'b1, 16'h0C00});
    serve_tx("t2 cmd", 20);
    rx_word("t2 status", 16'h0800, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) rx_word("t2 data", 16'hD000 + 16'(i), 1'b0, 1'b0, 1'b1, 5'(i));
    wait_done("t2", 4'b0000, 16'h0800, 20);
    // no response on either attempt
    mem[0] = 16'hA001;
    issue("t3", 5'd5, 1'b0, 5'd2, 5'd1);
    exp_tx.push_back({1'b1, 16'h2841});
    exp_tx.push_back({1'b0, 16'hA001});
    serve_tx("t3 cmd", 20);
    serve_tx("t3 data", 20);
    t1 = cyc;
    exp_tx.push_back({1'b1, 16'h2841});
    exp_tx.push_back({1'b0, 16'hA001});
    serve_tx("t3 retry cmd", 1500);
    chk("t3 retry spacing", (last_tx_cyc - t1) >= RT + RG, 1);
    serve_tx("t3 retry data", 20);
    wait_done("t3", 4'b0001, 16'h0000, 1500);
    chk("t3 done latency", (done_cyc - acc_cyc) >= 2 * RT, 1);
    // wrong RT address first, correct on retry
    issue("t4", 5'd5, 1'b0, 5'd2, 5'd1);
    exp_tx.push_back({1'b1, 16'h2841});
    exp_tx.push_back({1'b0, 16'hA001});
    serve_tx("t4 cmd", 20);
    serve_tx("t4 data", 20);
    rx_word("t4 status bad", 16'h3000, 1'b1, 1'b0, 1'b0, 5'd0);
    exp_tx.push_back({1'b1, 16'h2841});
    exp_tx.push_back({1'b0, 16'hA001});
    serve_tx("t4 retry cmd", 200);
    serve_tx("t4 retry data", 20);
    rx_word("t4 status ok", 16'h2800, 1'b1, 1'b0, 1'b0, 5'd0);
    wait_done("t4", 4'b0000, 16'h2800, 20);
    // message-error bit on both attempts
    issue("t5", 5'd5, 1'b0, 5'd2, 5'd1);
    for (int a = 0; a < 2; a++) begin
      exp_tx.push_back({1'b1, 16'h2841});
      exp_tx.push_back({1'b0, 16'hA001});
      serve_tx("t5 cmd", 200);
      serve_tx("t5 data", 20);
      rx_word("t5 status", 16'h2C00, 1'b1, 1'b0, 1'b0, 5'd0);
    end
    wait_done("t5", 4'b1000, 16'h2C00, 20);
    // parity error on the status word on both attempts
    issue("t5p", 5'd5, 1'b0, 5'd2, 5'd1);
    for (int a = 0; a < 2; a++) begin
      exp_tx.push_back({1'b1, 16'h2841});
      exp_tx.push_back({1'b0, 16'hA001});
      serve_tx("t5p cmd", 200);
      serve_tx("t5p data", 20);
      rx_word("t5p status", 16'h2800, 1'b1, 1'b1, 1'b0, 5'd0);
    end
    wait_done("t5p", 4'b0010, 16'h2800, 20);
    // reset in the middle of the data phase
    issue("t6", 5'd5, 1'b0, 5'd2, 5'd3);
    exp_tx.push_back({1'b1, 16'h2843});
    exp_tx.push_back({1'b0, 16'hA001});
    serve_tx("t6 cmd", 20);
    serve_tx("t6 data", 20);
    for (int n = 0; n < 20 && !tx_ready; n++) @(negedge clk);
    chk("t6 in send_data", {tx_ready, tx_cd}, 2'b10);
    reset = 1'b1;
    #1;
    chk("t6 tx_ready abort", tx_ready, 0);
    chk("t6 busy abort", busy, 0);
    seen_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      seen_done |= done;
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      seen_done |= done;
    end
    chk("t6 no done", seen_done, 0);
    exp_tx.delete();
    // fresh transfer after reset
    mem[0] = 16'hB001; mem[1] = 16'hB002; mem[2] = 16'hB003;
    issue("t7", 5'd5, 1'b0, 5'd2, 5'd3);
    exp_tx.push_back({1'b1, 16'h2843});
    exp_tx.push_back({1'b0, 16'hB001});
    exp_tx.push_back({1'b0, 16'hB002});
    exp_tx.push_back({1'b0, 16'hB003});
    for (int i = 0; i < 4; i++) serve_tx("t7 word", 20);
    rx_word("t7 status", 16'h2800, 1'b1, 1'b0, 1'b0, 5'd0);
    wait_done("t7", 4'b0000, 16'h2800, 20);
    chk("scoreboard empty", exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mkio_bc_sequencer.md
Name: mkio_bc_sequencer

Overview:
- Bus-controller-side transaction sequencer for the MKIO (MIL-STD-1553-style) channel.
- Accepts one transfer request at a time and drives the shared Manchester encoder (tx_*) and decoder (rx_*) interfaces.
- For BC->RT transfers it emits the command word plus data words fetched from a transmit buffer; for RT->BC transfers it captures the returned data words into a receive buffer.
- Validates the RT status word, applies a response timeout and retries failed transfers up to a parameterised count.

Parameters:
- RESP_TIMEOUT, 700, clk cycles allowed from tx_busy falling (end of own transmission) to rx_done of the expected word; also the inter-word limit while receiving data.
- RETRIES, 1, extra attempts after a failed attempt; 0 = no retry.
- RETRY_GAP, 50, idle clk cycles between a failed attempt and the next attempt.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  transfer request
- cmd_ready  out  1  high only in IDLE
- cmd_rt  in  5  target RT address
- cmd_tr  in  1  0 = BC->RT, 1 = RT->BC
- cmd_sa  in  5  subaddress
- cmd_wc  in  5  word count; 0 means 32
- tx_data  out  16  word to encoder
- tx_cd  out  1  1 = command-sync word, 0 = data-sync word
- tx_ready  out  1  word valid to encoder
- tx_busy  in  1  encoder transmitting
- rx_done  in  1  one-cycle pulse, decoded word valid
- rx_data  in  16  decoded word
- rx_cd  in  1  sync type of decoded word (1 = command/status)
- p_error  in  1  parity error, qualified by rx_done
- mem_addr  out  5  transmit buffer read address; synchronous read, data valid 1 clk later
- mem_data  in  16  transmit buffer data
- rxbuf_we  out  1  receive buffer write strobe
- rxbuf_addr  out  5  receive buffer write address
- rxbuf_data  out  16  receive buffer write data
- busy  out  1  high from accept to done
- done  out  1  one-cycle completion pulse
- status_word  out  16  last received status word
- err_flags  out  4  bit0 timeout, bit1 parity/format, bit2 address mismatch, bit3 message-error bit (status[10])

Behaviour:
- Reset (async): state IDLE; all outputs 0 except cmd_ready = 1.
- Accept: cmd_valid && cmd_ready latches cmd_* on the clock edge. On the same edge err_flags and status_word clear, busy rises and cmd_ready falls. Requests presented while busy are ignored.
- Command word: {cmd_rt, cmd_tr, cmd_sa, cmd_wc}. Effective word count N = (cmd_wc == 0) ? 32 : cmd_wc.
- Tx handshake, per word: assert tx_ready with tx_data/tx_cd stable; hold until tx_busy is sampled high; drop tx_ready the next cycle; wait for tx_busy low before the next word.
- State machine:
  - IDLE
  - SEND_CMD: tx_cd = 1. Next state is FETCH when tr = 0, or WAIT_STATUS when tr = 1.
  - FETCH: drive mem_addr = word index; wait 1 clk for read latency.
  - SEND_DATA: tx_cd = 0, tx_data = mem_data. Loop back to FETCH until N words are sent, then go to WAIT_STATUS.
  - WAIT_STATUS: timer loads RESP_TIMEOUT on tx_busy falling. Expects rx_done with rx_cd = 1. Next state is CHECK when tr = 0, or RECV_DATA when tr = 1.
  - RECV_DATA: expects N words with rx_cd = 0. Each word: rxbuf_we pulses 1 clk with rxbuf_addr = index 0..N-1; timer reloads on every word.
  - CHECK
  - RETRY_GAP
  - DONE
- Error detection:
  - Timer reaches 0 -> err_flags[0].
  - p_error on any rx_done -> err_flags[1].
  - Wrong sync type (rx_cd mismatch) -> err_flags[1]; the word is not written to the receive buffer.
  - status_word[15:11] != cmd_rt -> err_flags[2].
  - status_word[10] = 1 -> err_flags[3].
  - Received words are written to the receive buffer even when p_error is set.
- CHECK:
  - err_flags == 0 -> DONE.
  - Errors with attempts remaining -> RETRY_GAP: hold RETRY_GAP cycles, then SEND_CMD with the word index reset and err_flags cleared.
  - Attempts exhausted -> DONE with err_flags of the last attempt.
  - A timeout goes to CHECK immediately.
- DONE: done = 1 for 1 clk; next state IDLE. status_word and err_flags hold until the next accept.
- rx_done in IDLE, SEND_*, FETCH or RETRY_GAP is ignored.
- Word index is 5-bit; N = 32 terminates at index 31 with no wrap.
- Reset mid-transfer aborts immediately and no done pulse is issued.

Decomposition:
- mkio_pkg holds:
  - seq_state_t enum
  - command-word field positions
  - function mkio_cmd_word(rt, tr, sa, wc)
  - err_flags bit index constants
  - status-word field positions (address [15:11], message error [10])
- Sub-module mkio_resp_timer: loadable down-counter.
  - Ports: clk, reset, load, value, en, expired.
  - Width $clog2(RESP_TIMEOUT+1).

Test Plan:
- BC->RT, rt = 5, sa = 2, wc = 3, mem = {A001, A002, A003} -> tx words: 2843 (cd = 1), then A001, A002, A003 (cd = 0). Status 2800 returned -> done, err_flags = 0, status_word = 2800.
- RT->BC, rt = 1, tr = 1, wc = 0 -> cmd word 0C00. Status 0800, then 32 data words -> 32 rxbuf_we pulses at addr 0..31, done, err_flags = 0.
- No response, RETRIES = 1 -> command sent twice, separated by ≥ RETRY_GAP cycles. done asserts 2×RESP_TIMEOUT plus transmit time after accept; err_flags = 0001.
- Status address 06 instead of 05 on the first attempt, correct on the retry -> done with err_flags = 0.
- Status 2C00 (message-error bit set) on both attempts -> err_flags = 1000.
- Reset asserted during SEND_DATA -> tx_ready = 0 and busy = 0 immediately, no done pulse. A new request accepted after reset completes normally.
